// File: rtl/mem_lsu_pkg.sv
// Shared widths, memory opcodes and LSU state encodings for the MEM-stage load/store unit.
package mem_lsu_pkg;

  localparam int RADDR_WIDTH = 5;
  localparam int RDATA_WIDTH = 32;
  localparam int ADDR_WIDTH  = 32;
  localparam int DATA_WIDTH  = 32;

  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LH  = 4'd2,
    MEM_LW  = 4'd3,
    MEM_LBU = 4'd4,
    MEM_LHU = 4'd5,
    MEM_SB  = 4'd6,
    MEM_SH  = 4'd7,
    MEM_SW  = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_BUSY = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_e;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op >= 4'(MEM_LB)) && (op <= 4'(MEM_SW));
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == 4'(MEM_SB)) || (op == 4'(MEM_SH)) || (op == 4'(MEM_SW));
  endfunction

  function automatic logic op_aligned(input logic [3:0] op, input logic [1:0] a);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: return ~a[0];
      MEM_LW, MEM_SW:          return (a == 2'b00);
      default:                 return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_lane.sv
// Combinational byte-lane logic: store lane replication/byte enables and load extraction/extension.
module lsu_lane
  import mem_lsu_pkg::*;
(
  input  logic [3:0]            op_i,
  input  logic [1:0]            addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic [3:0]            be_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [DATA_WIDTH-1:0] load_o
);

  logic [DATA_WIDTH-1:0] shifted;

  function automatic logic [DATA_WIDTH-1:0] sext8(input logic signed [7:0] v);
    logic signed [DATA_WIDTH-1:0] r;
    r = v;
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sext16(input logic signed [15:0] v);
    logic signed [DATA_WIDTH-1:0] r;
    r = v;
    return r;
  endfunction

  always_comb begin
    shifted = rdata_i >> {addr_i, 3'b000};
    be_o    = 4'b0000;
    wdata_o = data_i;
    load_o  = shifted;
    case (op_i)
      MEM_LB, MEM_LBU, MEM_SB: begin
        be_o    = 4'b0001 << addr_i;
        wdata_o = {4{data_i[7:0]}};
      end
      MEM_LH, MEM_LHU, MEM_SH: begin
        be_o    = 4'b0011 << {addr_i[1], 1'b0};
        wdata_o = {2{data_i[15:0]}};
      end
      MEM_LW, MEM_SW: be_o = 4'b1111;
      default: ;
    endcase
    case (op_i)
      MEM_LB:  load_o = sext8(shifted[7:0]);
      MEM_LBU: load_o = DATA_WIDTH'(shifted[7:0]);
      MEM_LH:  load_o = sext16(shifted[15:0]);
      MEM_LHU: load_o = DATA_WIDTH'(shifted[15:0]);
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: single-outstanding blocking data-bus access with pipeline stall.
// Optional BUS_TIMEOUT_EN adds an ack watchdog and the bus_err_o pulse output.
module mem_lsu
  import mem_lsu_pkg::*;
`ifdef BUS_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = 255
)
`endif
(
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
  input  logic                   reg_we_i,
  input  logic [RDATA_WIDTH-1:0] reg_wdata_i,
  input  logic                   mem_we_i,
  input  logic [ADDR_WIDTH-1:0]  mem_addr_i,
  input  logic [DATA_WIDTH-1:0]  mem_data_i,
  input  logic [3:0]             mem_op_i,
  input  logic                   hold_i,
  output logic [RADDR_WIDTH-1:0] reg_waddr_o,
  output logic                   reg_we_o,
  output logic [RDATA_WIDTH-1:0] reg_wdata_o,
  output logic                   stallreq_o,
  output logic                   misalign_o,
  output logic                   dbus_req_o,
  output logic                   dbus_we_o,
  output logic [ADDR_WIDTH-1:0]  dbus_addr_o,
  output logic [3:0]             dbus_be_o,
  output logic [DATA_WIDTH-1:0]  dbus_wdata_o,
  input  logic                   dbus_ack_i,
  input  logic [DATA_WIDTH-1:0]  dbus_rdata_i
`ifdef BUS_TIMEOUT_EN
  ,
  output logic                   bus_err_o
`endif
);

  lsu_state_e            state_q, state_d;
  logic [3:0]            op_q;
  logic [1:0]            addr_lo_q;
  logic [DATA_WIDTH-1:0] load_q;
  logic [3:0]            lane_op;
  logic [1:0]            lane_addr;
  logic [3:0]            lane_be;
  logic [DATA_WIDTH-1:0] lane_wdata, lane_load;
  logic                  pending, misaligned, start, timeout, err_q;

  assign pending    = is_mem_op(mem_op_i) && op_aligned(mem_op_i, mem_addr_i[1:0]);
  assign misaligned = is_mem_op(mem_op_i) && !op_aligned(mem_op_i, mem_addr_i[1:0]);
  assign start      = (state_q == LSU_IDLE) && pending;

  // Store lanes come from the live request; load extraction uses the captured op/offset.
  assign lane_op   = (state_q == LSU_IDLE) ? mem_op_i : op_q;
  assign lane_addr = (state_q == LSU_IDLE) ? mem_addr_i[1:0] : addr_lo_q;

  lsu_lane u_lane (
    .op_i    (lane_op),
    .addr_i  (lane_addr),
    .data_i  (mem_data_i),
    .rdata_i (dbus_rdata_i),
    .be_o    (lane_be),
    .wdata_o (lane_wdata),
    .load_o  (lane_load)
  );

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q;

  assign timeout = (state_q == LSU_BUSY) && !dbus_ack_i &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q     <= '0;
      err_q     <= 1'b0;
      bus_err_o <= 1'b0;
    end else begin
      cnt_q     <= (state_q == LSU_BUSY) ? cnt_q + 1'b1 : '0;
      bus_err_o <= timeout;
      if (start)
        err_q <= 1'b0;
      else if (timeout)
        err_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err_q   = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    stallreq_o  = 1'b0;
    misalign_o  = 1'b0;
    reg_waddr_o = reg_waddr_i;
    reg_we_o    = reg_we_i;
    reg_wdata_o = reg_wdata_i;
    case (state_q)
      LSU_IDLE: begin
        if (misaligned) begin
          misalign_o = 1'b1;
          reg_we_o   = 1'b0;
        end else if (pending) begin
          stallreq_o = 1'b1;
          reg_we_o   = 1'b0;
          state_d    = LSU_BUSY;
        end
      end
      LSU_BUSY: begin
        stallreq_o = 1'b1;
        reg_we_o   = 1'b0;
        if (dbus_ack_i || timeout)
          state_d = LSU_DONE;
      end
      LSU_DONE: begin
        if (is_store(op_q) || err_q)
          reg_we_o = 1'b0;
        else
          reg_wdata_o = load_q;
        if (!hold_i)
          state_d = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= LSU_IDLE;
      dbus_req_o   <= 1'b0;
      dbus_we_o    <= 1'b0;
      dbus_addr_o  <= '0;
      dbus_be_o    <= 4'b0000;
      dbus_wdata_o <= '0;
      op_q         <= 4'(MEM_NOP);
      addr_lo_q    <= 2'b00;
      load_q       <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        dbus_req_o   <= 1'b1;
        dbus_we_o    <= mem_we_i;
        dbus_addr_o  <= {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
        dbus_be_o    <= lane_be;
        dbus_wdata_o <= lane_wdata;
        op_q         <= mem_op_i;
        addr_lo_q    <= mem_addr_i[1:0];
      end else if ((state_q == LSU_BUSY) && (dbus_ack_i || timeout)) begin
        dbus_req_o <= 1'b0;
        if (dbus_ack_i)
          load_q <= lane_load;
      end
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: stimulus pushes expected bus/retire records, a monitor pops and compares.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [4:0]  reg_waddr_i, reg_waddr_o;
  logic        reg_we_i, reg_we_o;
  logic [31:0] reg_wdata_i, reg_wdata_o;
  logic        mem_we_i;
  logic [31:0] mem_addr_i, mem_data_i;
  logic [3:0]  mem_op_i;
  logic        hold_i;
  logic        stallreq_o, misalign_o;
  logic        dbus_req_o, dbus_we_o;
  logic [31:0] dbus_addr_o, dbus_wdata_o;
  logic [3:0]  dbus_be_o;
  logic        dbus_ack_i;
  logic [31:0] dbus_rdata_i;
`ifdef BUS_TIMEOUT_EN
  logic        bus_err_o;
`endif

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    logic        we;
    logic [31:0] wdata;
    logic [4:0]  waddr;
    logic        mis;
    int          stall;
    int          reqs;
  } ret_t;

  bus_t bus_q[$];
  ret_t ret_q[$];
  int   checks = 0;
  int   errors = 0;
  logic        ack_en = 1'b1;
  int          ack_wait = 0;
  logic [31:0] rdata_next = '0;

  mem_lsu dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .reg_waddr_i  (reg_waddr_i),
    .reg_we_i     (reg_we_i),
    .reg_wdata_i  (reg_wdata_i),
    .mem_we_i     (mem_we_i),
    .mem_addr_i   (mem_addr_i),
    .mem_data_i   (mem_data_i),
    .mem_op_i     (mem_op_i),
    .hold_i       (hold_i),
    .reg_waddr_o  (reg_waddr_o),
    .reg_we_o     (reg_we_o),
    .reg_wdata_o  (reg_wdata_o),
    .stallreq_o   (stallreq_o),
    .misalign_o   (misalign_o),
    .dbus_req_o   (dbus_req_o),
    .dbus_we_o    (dbus_we_o),
    .dbus_addr_o  (dbus_addr_o),
    .dbus_be_o    (dbus_be_o),
    .dbus_wdata_o (dbus_wdata_o),
    .dbus_ack_i   (dbus_ack_i),
    .dbus_rdata_i (dbus_rdata_i)
`ifdef BUS_TIMEOUT_EN
    ,
    .bus_err_o    (bus_err_o)
`endif
  );

  initial forever #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus slave: acks after ack_wait cycles of a visible request.
  initial begin
    int wcnt;
    wcnt = 0;
    dbus_ack_i = 1'b0;
    dbus_rdata_i = '0;
    forever begin
      @(posedge clk_i);
      #1;
      if (dbus_req_o && ack_en && rst_n_i) begin
        if (wcnt >= ack_wait) begin
          dbus_ack_i   = 1'b1;
          dbus_rdata_i = rdata_next;
        end else begin
          wcnt++;
        end
      end else begin
        dbus_ack_i = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Monitor: bus request rising edges and instruction retirement.
  initial begin
    logic req_prev;
    int   stall_cnt, req_cnt;
    bus_t b;
    ret_t r;
    req_prev = 1'b0;
    stall_cnt = 0;
    req_cnt = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_n_i) begin
        stall_cnt = 0;
        req_cnt = 0;
        req_prev = dbus_req_o;
        continue;
      end
      if (dbus_req_o && !req_prev) begin
        req_cnt++;
        if (bus_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bus_unexpected: got request addr %h expected none", dbus_addr_o);
        end else begin
          b = bus_q.pop_front();
          chk("bus_we", 32'(dbus_we_o), 32'(b.we));
          chk("bus_addr", dbus_addr_o, b.addr);
          chk("bus_be", 32'(dbus_be_o), 32'(b.be));
          chk("bus_wdata", dbus_wdata_o, b.wdata);
        end
      end
      req_prev = dbus_req_o;
      if (stallreq_o) begin
        stall_cnt++;
      end else if (mem_op_i != 4'(MEM_NOP) || reg_we_i) begin
        if (ret_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ret_unexpected: got retire op %0d expected none", mem_op_i);
        end else begin
          r = ret_q.pop_front();
          chk("ret_we", 32'(reg_we_o), 32'(r.we));
          chk("ret_waddr", 32'(reg_waddr_o), 32'(r.waddr));
          chk("ret_misalign", 32'(misalign_o), 32'(r.mis));
          chk("ret_stall_cycles", 32'(stall_cnt), 32'(r.stall));
          chk("ret_req_count", 32'(req_cnt), 32'(r.reqs));
          if (r.we) chk("ret_wdata", reg_wdata_o, r.wdata);
        end
        stall_cnt = 0;
        req_cnt = 0;
      end
    end
  end

  task automatic idle();
    @(posedge clk_i);
    #1;
    mem_op_i = 4'(MEM_NOP);
    mem_we_i = 1'b0;
    mem_addr_i = '0;
    mem_data_i = '0;
    reg_we_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic run(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                     input logic [31:0] rdata, input int wt, input int holds,
                     input logic e_we, input logic [31:0] e_wd, input logic e_mis, input int e_stall,
                     input logic [31:0] e_baddr, input logic [3:0] e_be, input logic [31:0] e_bwd);
    bus_t b;
    ret_t r;
    int   n;
    logic st;
    logic acc;
    st  = (op == 4'(MEM_SB)) || (op == 4'(MEM_SH)) || (op == 4'(MEM_SW));
    acc = !e_mis && (op != 4'(MEM_NOP));
    if (acc) begin
      b = '{st, e_baddr, e_be, e_bwd};
      bus_q.push_back(b);
    end
    r = '{e_we, e_wd, 5'd9, e_mis, e_stall, acc ? 1 : 0};
    ret_q.push_back(r);
    for (int i = 0; i < holds; i++) begin
      r.stall = 0;
      r.reqs = 0;
      ret_q.push_back(r);
    end
    @(posedge clk_i);
    #1;
    mem_op_i = op;
    mem_addr_i = addr;
    mem_data_i = data;
    mem_we_i = st;
    reg_we_i = 1'b1;
    reg_waddr_i = 5'd9;
    reg_wdata_i = 32'hA5A5_0000;
    rdata_next = rdata;
    ack_wait = wt;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (stallreq_o && n < 1000);
    checks++;
    if (stallreq_o) begin
      errors++;
      $display("FAIL stall_bound: got stallreq 1 after %0d cycles expected 0", n);
    end
    if (holds > 0) begin
      hold_i = 1'b1;
      repeat (holds) @(negedge clk_i);
      hold_i = 1'b0;
    end
  endtask

  initial begin
    rst_n_i = 1'b0;
    hold_i = 1'b0;
    mem_op_i = 4'(MEM_NOP);
    mem_we_i = 1'b0;
    mem_addr_i = '0;
    mem_data_i = '0;
    reg_we_i = 1'b0;
    reg_waddr_i = '0;
    reg_wdata_i = '0;
    repeat (2) @(negedge clk_i);
    chk("rst_req", 32'(dbus_req_o), 32'd0);
    chk("rst_we", 32'(dbus_we_o), 32'd0);
    chk("rst_be", 32'(dbus_be_o), 32'd0);
    chk("rst_addr", dbus_addr_o, 32'd0);
    chk("rst_wdata", dbus_wdata_o, 32'd0);
    chk("rst_stall", 32'(stallreq_o), 32'd0);
    chk("rst_misalign", 32'(misalign_o), 32'd0);
    rst_n_i = 1'b1;

    //   op       addr       data          rdata          wt h  we  wdata          mis st  baddr     be       bus wdata
    run(MEM_SW,  32'h100, 32'hDEADBEEF, 32'h0,          0, 0, 0, 32'h0,          0, 2, 32'h100, 4'b1111, 32'hDEADBEEF);
    run(MEM_LB,  32'h103, 32'h0,        32'h80123456,   0, 0, 1, 32'hFFFFFF80,   0, 2, 32'h100, 4'b1000, 32'h0);
    run(MEM_LBU, 32'h103, 32'h0,        32'h80123456,   0, 0, 1, 32'h00000080,   0, 2, 32'h100, 4'b1000, 32'h0);
    run(MEM_LH,  32'h102, 32'h0,        32'h8001ABCD,   0, 0, 1, 32'hFFFF8001,   0, 2, 32'h100, 4'b1100, 32'h0);
    run(MEM_SH,  32'h102, 32'h00001234, 32'h0,          0, 0, 0, 32'h0,          0, 2, 32'h100, 4'b1100, 32'h12341234);
    run(MEM_LW,  32'h101, 32'h0,        32'h0,          0, 0, 0, 32'h0,          1, 0, 32'h0,   4'b0000, 32'h0);
    run(MEM_LW,  32'h200, 32'h0,        32'h13579BDF,   3, 2, 1, 32'h13579BDF,   0, 5, 32'h200, 4'b1111, 32'h0);
    run(MEM_NOP, 32'h0,   32'h0,        32'h0,          0, 0, 1, 32'hA5A50000,   0, 0, 32'h0,   4'b0000, 32'h0);
    run(MEM_SB,  32'h201, 32'h000000AB, 32'h0,          0, 0, 0, 32'h0,          0, 2, 32'h200, 4'b0010, 32'hABABABAB);
    run(MEM_LHU, 32'h100, 32'h0,        32'h1234F00D,   0, 0, 1, 32'h0000F00D,   0, 2, 32'h100, 4'b0011, 32'h0);
    run(MEM_SH,  32'h103, 32'h00005555, 32'h0,          0, 0, 0, 32'h0,          1, 0, 32'h0,   4'b0000, 32'h0);
    run(MEM_LB,  32'h102, 32'h0,        32'h00C30000,   1, 0, 1, 32'hFFFFFFC3,   0, 3, 32'h100, 4'b0100, 32'h0);
    idle();

    // Reset while the bus access is in flight abandons the instruction.
    bus_q.push_back('{1'b0, 32'h300, 4'b1111, 32'h0});
    ack_wait = 20;
    @(posedge clk_i);
    #1;
    mem_op_i = 4'(MEM_LW);
    mem_addr_i = 32'h300;
    mem_we_i = 1'b0;
    reg_we_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("busy_req_before_rst", 32'(dbus_req_o), 32'd1);
    #2 rst_n_i = 1'b0;
    #1;
    chk("rst_mid_req", 32'(dbus_req_o), 32'd0);
    chk("rst_mid_state", 32'(dut.state_q), 32'(LSU_IDLE));
    mem_op_i = 4'(MEM_NOP);
    mem_addr_i = '0;
    reg_we_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    ack_wait = 0;
    idle();
    chk("post_rst_req", 32'(dbus_req_o), 32'd0);

`ifdef BUS_TIMEOUT_EN
    ack_en = 1'b0;
    run(MEM_LW, 32'h400, 32'h0, 32'h0, 0, 0, 0, 32'h0, 0, 256, 32'h400, 4'b1111, 32'h0);
    chk("bus_err_pulse", 32'(bus_err_o), 32'd1);
    ack_en = 1'b1;
    idle();
    chk("bus_err_drop", 32'(bus_err_o), 32'd0);
`endif

    repeat (3) idle();
    chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
    chk("ret_q_drained", 32'(ret_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- MEM-stage load/store unit, the consumer of the exe-to-mem memory request (mem_we/mem_addr/mem_data/mem_op) and of the register-write bundle.
- Runs a blocking single-outstanding data-bus transaction, handling byte-lane placement for stores and lane extraction plus sign/zero extension for loads.
- Stalls the pipeline through pipe_ctrl while the access is in flight; non-memory instructions pass straight through.

Parameters:
TIMEOUT_CYCLES, 255, ack wait limit in cycles; used only when BUS_TIMEOUT_EN is defined.

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset, asynchronous, active-low
reg_waddr_i  in  RADDR_WIDTH  destination register from exe_mem
reg_we_i  in  1  register write enable from exe_mem
reg_wdata_i  in  RDATA_WIDTH  ALU result from exe_mem
mem_we_i  in  1  store flag
mem_addr_i  in  ADDR_WIDTH  byte address
mem_data_i  in  DATA_WIDTH  store data, right-aligned
mem_op_i  in  4  MEM_NOP/LB/LH/LW/LBU/LHU/SB/SH/SW
hold_i  in  1  pipe_ctrl holds this stage
reg_waddr_o  out  RADDR_WIDTH  to mem_wb
reg_we_o  out  1  to mem_wb
reg_wdata_o  out  RDATA_WIDTH  to mem_wb
stallreq_o  out  1  to pipe_ctrl
misalign_o  out  1  one-cycle misaligned-access flag
dbus_req_o  out  1  bus request, registered
dbus_we_o  out  1  bus write
dbus_addr_o  out  ADDR_WIDTH  word address, bits [1:0] = 0
dbus_be_o  out  4  byte enables
dbus_wdata_o  out  DATA_WIDTH  lane-replicated store data
dbus_ack_i  in  1  transfer complete; rdata valid this cycle
dbus_rdata_i  in  DATA_WIDTH  read word
bus_err_o  out  1  timeout pulse (present only with BUS_TIMEOUT_EN)

Behaviour:
- Reset values:
  - State IDLE.
  - dbus_req_o/dbus_we_o/dbus_be_o/dbus_addr_o/dbus_wdata_o = 0.
  - Internal data register = 0.
  - misalign_o = 0, bus_err_o = 0.
- FSM states: IDLE, BUSY, DONE.
- Access pending condition: mem_op_i != MEM_NOP and the address is aligned.
- Alignment rules:
  - LH/LHU/SH require addr[0] = 0.
  - LW/SW require addr[1:0] = 0.
  - Byte accesses are always aligned.
- IDLE:
  - mem_op_i == MEM_NOP: reg_* outputs pass through combinationally; stallreq_o = 0.
  - Misaligned access: no bus access, reg_we_o = 0, stallreq_o = 0, misalign_o = 1 for that cycle.
  - Access pending: stallreq_o = 1 combinationally. Next cycle dbus_req_o = 1 with registered we/addr/be/wdata, and the FSM goes to BUSY.
- BUSY:
  - stallreq_o = 1 and dbus_req_o held stable.
  - On dbus_ack_i: latch the extended load data, drop dbus_req_o, go to DONE.
  - ack in the first BUSY cycle is legal, giving a minimum of 2 stall cycles.
- DONE:
  - stallreq_o = 0.
  - Loads: reg_wdata_o = latched data, reg_we_o = reg_we_i.
  - Stores: reg_we_o = 0.
  - If hold_i = 1, stay in DONE and keep outputs stable (no repeated access); otherwise go to IDLE.
- Store lane placement:
  - SB: wdata = {4{d[7:0]}}, be = 4'b0001 << addr[1:0].
  - SH: wdata = {2{d[15:0]}}, be = 4'b0011 << {addr[1],1'b0}.
  - SW: wdata = d, be = 4'b1111.
- Load lane extraction:
  - Byte enables follow the same rule as stores.
  - Shift rdata right by 8*addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- dbus_addr_o = {addr[ADDR_WIDTH-1:2], 2'b00}.
- Async reset asserted in BUSY or DONE:
  - Immediate return to IDLE with dbus_req_o = 0; the bus must tolerate the abandoned request.
  - The instruction is not retired.
- dbus_ack_i in IDLE or DONE is ignored.

Optional Feature:
- BUS_TIMEOUT_EN defined:
  - An 8+ bit counter runs in BUSY.
  - After TIMEOUT_CYCLES cycles without ack: drop the request, pulse bus_err_o for 1 cycle, go to DONE with reg_we_o = 0.
- BUS_TIMEOUT_EN undefined:
  - No counter and no bus_err_o port; BUSY waits indefinitely for ack.

Decomposition:
- defines.v holds:
  - MEM_NOP/MEM_LB/MEM_LH/MEM_LW/MEM_LBU/MEM_LHU/MEM_SB/MEM_SH/MEM_SW codes (0..8).
  - LSU state encodings.
  - Existing width macros.
- One sub-module: lsu_lane, combinational. It computes be/wdata from op+addr+data and the extended load value from op+addr+rdata. The FSM stays in mem_lsu.

Test Plan:
- SW addr 0x100, d 0xDEADBEEF, ack in first BUSY cycle -> one req cycle, be 1111, dbus_addr 0x100, wdata 0xDEADBEEF, stallreq 2 cycles, reg_we_o 0.
- LB addr 0x103, rdata 0x80123456 -> reg_wdata_o 0xFFFFFF80, be 1000; LBU same -> 0x00000080.
- LH addr 0x102, rdata 0x8001ABCD -> 0xFFFF8001; SH addr 0x102, d 0x00001234 -> wdata 0x12341234, be 1100.
- LW addr 0x101 -> misalign_o 1 for one cycle, dbus_req_o never rises, stallreq_o 0, reg_we_o 0.
- LW, ack after 3 wait cycles, then hold_i = 1 for 2 DONE cycles -> exactly one req, stallreq 5 cycles, result stable across the hold.
- rst_n_i low mid-BUSY -> dbus_req_o 0 at once, FSM in IDLE. With BUS_TIMEOUT_EN and no ack -> bus_err_o pulses after 255 BUSY cycles.
